// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard and forwarding controller for the pipelined RV32I core.
//   - EX operand forwarding from NSTG downstream result stages.
//     The nearest stage wins: index 0 is M, index NSTG-1 is W.
//   - Sequential hazard control, highest priority first:
//       1. data-memory wait stall (mw)
//       2. branch-taken flush
//       3. multi-bubble load-use stall
//
// Parameters:
//   NSTG       forwarding source stages after EX (1..6)
//   LU_BUBBLES bubbles inserted per load-use hazard (1..7)
//   FW         forward-select code width (derived, do not override)
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   Rs1D, Rs2D                Decode source registers
//   Rs1E, Rs2E, RdE           Execute source/destination registers
//   RegWriteE, ResultSrcE0    Execute writes rd / Execute is a load
//   PCSrcE                    branch/jump taken in Execute
//   RdS, RegWriteS            per-stage destination regs and write enables
//   MemReqM, MemReadyM        data memory request / completion in M
//   ForwardA, ForwardB        operand select codes (NSTG-i, or 0 = regfile)
//   StallF/D/E/M              pipeline register holds
//   FlushD/E/W                pipeline register bubble inserts
//
// Optional feature, enabled by defining HAZARD_PERF_EN:
//   lu_stall_cnt              saturating count of load-use StallD cycles
//                             that occur without a memory wait
//   mem_stall_cnt             saturating count of memory-wait cycles
module hazard_ctrl_unit #(
   parameter int NSTG       = 2,
   parameter int LU_BUBBLES = 1,
   parameter int FW         = $clog2(NSTG + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        Rs1D,
   input  logic [4:0]        Rs2D,
   input  logic [4:0]        Rs1E,
   input  logic [4:0]        Rs2E,
   input  logic [4:0]        RdE,
   input  logic              RegWriteE,
   input  logic              ResultSrcE0,
   input  logic              PCSrcE,
   input  logic [5*NSTG-1:0] RdS,
   input  logic [NSTG-1:0]   RegWriteS,
   input  logic              MemReqM,
   input  logic              MemReadyM,
   output logic [FW-1:0]     ForwardA,
   output logic [FW-1:0]     ForwardB,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushW
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       lu_stall_cnt,
   output logic [31:0]       mem_stall_cnt
`endif
);

   localparam int CW = $clog2(LU_BUBBLES + 1);

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;

   logic lu_hz;
   logic mw;
   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic stall_m;
   logic flush_d;
   logic flush_e;
   logic flush_w;
   logic lu_stall_active;

   // The scan runs from the farthest stage to the nearest, so the last
   // match written (the lowest index) is the one that wins.
   function automatic logic [FW-1:0] fwd_sel(
      input logic [4:0]        rs,
      input logic [5*NSTG-1:0] rd,
      input logic [NSTG-1:0]   we
   );
      logic [FW-1:0] sel;
      sel = '0;
      for (int i = NSTG - 1; i >= 0; i--) begin
         if (we[i] && (rd[5*i +: 5] != 5'd0) && (rd[5*i +: 5] == rs)) begin
            sel = FW'(NSTG - i);
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction

   // Forwarding select codes for both EX operands.
   always_comb begin
      ForwardA = fwd_sel(Rs1E, RdS, RegWriteS);
      ForwardB = fwd_sel(Rs2E, RdS, RegWriteS);
   end

   assign lu_hz = ResultSrcE0 & RegWriteE & (RdE != 5'd0) &
                  ((RdE == Rs1D) | (RdE == Rs2D));
   assign mw    = MemReqM & ~MemReadyM;

   // FSM state and bubble-counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // FSM next-state and stall/flush decode.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_w    = 1'b0;
      if (mw) begin
         // The whole pipe freezes, so a taken branch held in E is
         // presented again once the memory completes.
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (PCSrcE) begin
                  // A load in D is squashed by the flush, so the hazard is moot.
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (lu_hz) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
                  if (LU_BUBBLES > 1) begin
                     next_state = LU_STALL;
                     next_cnt   = CW'(LU_BUBBLES - 1);
                  end else begin
                     next_state = RUN;
                     next_cnt   = '0;
                  end
               end else begin
                  next_state = RUN;
               end
            end
            LU_STALL: begin
               stall_f  = 1'b1;
               stall_d  = 1'b1;
               flush_e  = 1'b1;
               next_cnt = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  next_state = RUN;
               end else begin
                  next_state = LU_STALL;
               end
            end
            default: begin
               next_state = RUN;
               next_cnt   = '0;
            end
         endcase
      end
   end

   // Reset masks the controls immediately, without waiting for the
   // state register to settle.
   always_comb begin
      StallF = stall_f & ~rst;
      StallD = stall_d & ~rst;
      StallE = stall_e & ~rst;
      StallM = stall_m & ~rst;
      FlushD = flush_d & ~rst;
      FlushE = flush_e & ~rst;
      FlushW = flush_w & ~rst;
   end

   assign lu_stall_active = ~mw & ((state == LU_STALL) |
                                   ((state == RUN) & ~PCSrcE & lu_hz));

`ifdef HAZARD_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_stall_cnt  <= 32'd0;
         mem_stall_cnt <= 32'd0;
      end else begin
         if (lu_stall_active && (lu_stall_cnt != 32'hFFFF_FFFF)) begin
            lu_stall_cnt <= lu_stall_cnt + 32'd1;
         end else begin
            lu_stall_cnt <= lu_stall_cnt;
         end
         if (mw && (mem_stall_cnt != 32'hFFFF_FFFF)) begin
            mem_stall_cnt <= mem_stall_cnt + 32'd1;
         end else begin
            mem_stall_cnt <= mem_stall_cnt;
         end
      end
   end
`else
   logic unused_perf;
   assign unused_perf = lu_stall_active;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit.
// Two instances share the scalar inputs:
//   u_a  NSTG=2, LU_BUBBLES=1
//   u_b  NSTG=4, LU_BUBBLES=3
// Controls are packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
module tb_hazard_ctrl_unit;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
   logic RegWriteE, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;

   logic [9:0]  rds_a;
   logic [1:0]  rws_a;
   logic [1:0]  fa_a, fb_a;
   logic sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a;

   logic [19:0] rds_b;
   logic [3:0]  rws_b;
   logic [2:0]  fa_b, fb_b;
   logic sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b;

`ifdef HAZARD_PERF_EN
   logic [31:0] luc_a, mc_a, luc_b, mc_b;
`endif

   int total = 0;
   int bad   = 0;
   int rem_a = 0;   // load-use bubbles still owed after the current cycle
   int rem_b = 0;

   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LU   = 7'b1100010;
   localparam logic [6:0] C_MW   = 7'b1111001;
   localparam logic [6:0] C_BR   = 7'b0000110;

   wire [6:0] ctl_a = {sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a};
   wire [6:0] ctl_b = {sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b};

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.NSTG(2), .LU_BUBBLES(1)) u_a (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
      .RdS(rds_a), .RegWriteS(rws_a), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardA(fa_a), .ForwardB(fb_a), .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
      .StallM(sm_a), .FlushD(fd_a), .FlushE(fe_a), .FlushW(fw_a)
`ifdef HAZARD_PERF_EN
      , .lu_stall_cnt(luc_a), .mem_stall_cnt(mc_a)
`endif
   );

   hazard_ctrl_unit #(.NSTG(4), .LU_BUBBLES(3)) u_b (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
      .RdS(rds_b), .RegWriteS(rws_b), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardA(fa_b), .ForwardB(fb_b), .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
      .StallM(sm_b), .FlushD(fd_b), .FlushE(fe_b), .FlushW(fw_b)
`ifdef HAZARD_PERF_EN
      , .lu_stall_cnt(luc_b), .mem_stall_cnt(mc_b)
`endif
   );

   // ---------------- reference model ----------------
   function automatic logic lu_now();
      return ResultSrcE0 && RegWriteE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
   endfunction

   function automatic logic mw_now();
      return MemReqM && !MemReadyM;
   endfunction

   function automatic logic [6:0] exp_ctl(input int rem);
      if (rst)                return C_NONE;
      else if (mw_now())      return C_MW;
      else if (rem > 0)       return C_LU;
      else if (PCSrcE)        return C_BR;
      else if (lu_now())      return C_LU;
      else                    return C_NONE;
   endfunction

   function automatic int next_rem(input int rem, input int bubbles);
      if (rst)                return 0;
      else if (mw_now())      return rem;
      else if (rem > 0)       return rem - 1;
      else if (PCSrcE)        return 0;
      else if (lu_now())      return bubbles - 1;
      else                    return 0;
   endfunction

   // Nearest writing stage with a nonzero matching rd gives code n-i.
   function automatic int exp_fwd(input int n, input logic [29:0] rds,
                                  input logic [5:0] rws, input logic [4:0] rs);
      for (int i = 0; i < n; i++) begin
         if (rws[i] && rds[5*i +: 5] != 5'd0 && rds[5*i +: 5] == rs) return n - i;
      end
      return 0;
   endfunction

   // Advance one clock; inputs are left for the caller to change after negedge.
   task automatic tick();
      int na, nb;
      na = next_rem(rem_a, 1);
      nb = next_rem(rem_b, 3);
      @(posedge clk);
      rem_a = na;
      rem_b = nb;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
      RegWriteE = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0;
      rds_a = 10'd0; rws_a = 2'd0; rds_b = 20'd0; rws_b = 4'd0;
   endtask

   task automatic set_load_use();
      RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd1;
      ResultSrcE0 = 1'b1; RegWriteE = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      set_load_use();
      MemReqM = 1'b1;
      #1;
      total++;
      if (ctl_a !== C_NONE) begin bad++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, C_NONE); end
      total++;
      if (ctl_b !== C_NONE) begin bad++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, C_NONE); end
      // Forwarding stays live while reset is held.
      rds_a = {5'd4, 5'd4}; rws_a = 2'b11; Rs1E = 5'd4;
      #1;
      total++;
      if (fa_a !== 2'b10) begin bad++; $display("FAIL reset_fwd got=%b exp=10", fa_a); end
      tick();
      tick();
      clear_inputs();
      rst = 1'b0;
      rem_a = 0; rem_b = 0;
      #1;
      total++;
      if (ctl_b !== C_NONE) begin bad++; $display("FAIL reset_release got=%b exp=%b", ctl_b, C_NONE); end
      tick();
   endtask

   task automatic test_forwarding();
      clear_inputs();
      rds_a = {5'd3, 5'd3}; rws_a = 2'b11; Rs1E = 5'd3; #1;
      total++;
      if (fa_a !== 2'b10) begin bad++; $display("FAIL fwd_m got=%b exp=10", fa_a); end
      rws_a = 2'b10; #1;
      total++;
      if (fa_a !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b exp=01", fa_a); end
      rds_a = {5'd3, 5'd0}; rws_a = 2'b11; Rs2E = 5'd0; #1;
      total++;
      if (fb_a !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b exp=00", fb_a); end
      rds_b = {5'd5, 5'd5, 5'd9, 5'd6}; rws_b = 4'b1111; Rs1E = 5'd5; Rs2E = 5'd6; #1;
      total++;
      if (fa_b !== 3'd2) begin bad++; $display("FAIL fwd4_a got=%0d exp=2", fa_b); end
      total++;
      if (fb_b !== 3'd4) begin bad++; $display("FAIL fwd4_b got=%0d exp=4", fb_b); end
      for (int k = 0; k < 60; k++) begin
         rds_a = 10'($urandom_range(0, 1023)) & 10'b0001100011;
         rws_a = 2'($urandom_range(0, 3));
         rds_b = 20'($urandom) & 20'b00011000110001100011;
         rws_b = 4'($urandom_range(0, 15));
         Rs1E  = 5'($urandom_range(0, 3));
         Rs2E  = 5'($urandom_range(0, 3));
         #1;
         total++;
         if (fa_a !== 2'(exp_fwd(2, {20'd0, rds_a}, {4'd0, rws_a}, Rs1E)) ||
             fb_a !== 2'(exp_fwd(2, {20'd0, rds_a}, {4'd0, rws_a}, Rs2E))) begin
            bad++;
            $display("FAIL fwd_rand_a got=%b/%b rds=%h rws=%b rs=%0d/%0d", fa_a, fb_a, rds_a, rws_a, Rs1E, Rs2E);
         end
         total++;
         if (fa_b !== 3'(exp_fwd(4, {10'd0, rds_b}, {2'd0, rws_b}, Rs1E)) ||
             fb_b !== 3'(exp_fwd(4, {10'd0, rds_b}, {2'd0, rws_b}, Rs2E))) begin
            bad++;
            $display("FAIL fwd_rand_b got=%0d/%0d rds=%h rws=%b rs=%0d/%0d", fa_b, fb_b, rds_b, rws_b, Rs1E, Rs2E);
         end
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_load_use();
      logic [6:0] ea [4];
      logic [6:0] eb [4];
      ea = '{C_LU, C_NONE, C_NONE, C_NONE};
      eb = '{C_LU, C_LU, C_LU, C_NONE};
      clear_inputs();
      set_load_use();
      for (int c = 0; c < 4; c++) begin
         #1;
         total++;
         if (ctl_a !== ea[c]) begin bad++; $display("FAIL lu1_cyc%0d got=%b exp=%b", c, ctl_a, ea[c]); end
         total++;
         if (ctl_b !== eb[c]) begin bad++; $display("FAIL lu3_cyc%0d got=%b exp=%b", c, ctl_b, eb[c]); end
         tick();
         clear_inputs();
      end
   endtask

   task automatic test_mem_wait();
      logic [6:0] eb [8];
      eb = '{C_LU, C_MW, C_MW, C_MW, C_MW, C_LU, C_LU, C_NONE};
      clear_inputs();
      set_load_use();
      for (int c = 0; c < 8; c++) begin
         #1;
         total++;
         if (ctl_b !== eb[c]) begin bad++; $display("FAIL mw_cyc%0d got=%b exp=%b", c, ctl_b, eb[c]); end
         tick();
         clear_inputs();
         if (c < 4) begin
            MemReqM = 1'b1; MemReadyM = 1'b0;
         end else begin
            MemReqM = 1'b1; MemReadyM = 1'b1;
         end
      end
      clear_inputs();
   endtask

   task automatic test_branch_vs_lu();
      clear_inputs();
      set_load_use();
      PCSrcE = 1'b1;
      #1;
      total++;
      if (ctl_a !== C_BR) begin bad++; $display("FAIL br_lu_a got=%b exp=%b", ctl_a, C_BR); end
      total++;
      if (ctl_b !== C_BR) begin bad++; $display("FAIL br_lu_b got=%b exp=%b", ctl_b, C_BR); end
      tick();
      clear_inputs();
      #1;
      total++;
      if (ctl_b !== C_NONE) begin bad++; $display("FAIL br_no_lustall got=%b exp=%b", ctl_b, C_NONE); end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs();
      set_load_use();
      tick();
      clear_inputs();
      #1;
      total++;
      if (ctl_b !== C_LU) begin bad++; $display("FAIL rst_pre got=%b exp=%b", ctl_b, C_LU); end
      rst = 1'b1;
      #1;
      total++;
      if (ctl_b !== C_NONE) begin bad++; $display("FAIL rst_async got=%b exp=%b", ctl_b, C_NONE); end
      rem_a = 0; rem_b = 0;
      tick();
      rst = 1'b0;
      #1;
      total++;
      if (ctl_b !== C_NONE) begin bad++; $display("FAIL rst_run got=%b exp=%b", ctl_b, C_NONE); end
      tick();
      #1;
      total++;
      if (ctl_b !== C_NONE) begin bad++; $display("FAIL rst_run2 got=%b exp=%b", ctl_b, C_NONE); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         rst         = ($urandom_range(0, 49) == 0);
         Rs1D        = 5'($urandom_range(0, 3));
         Rs2D        = 5'($urandom_range(0, 3));
         RdE         = 5'($urandom_range(0, 3));
         RegWriteE   = 1'($urandom_range(0, 1));
         ResultSrcE0 = 1'($urandom_range(0, 1));
         PCSrcE      = ($urandom_range(0, 5) == 0);
         MemReqM     = ($urandom_range(0, 3) == 0);
         MemReadyM   = 1'($urandom_range(0, 1));
         #1;
         if (rst) begin rem_a = 0; rem_b = 0; end
         total++;
         if (ctl_a !== exp_ctl(rem_a)) begin
            bad++; $display("FAIL rand_a_%0d got=%b exp=%b", k, ctl_a, exp_ctl(rem_a));
         end
         total++;
         if (ctl_b !== exp_ctl(rem_b)) begin
            bad++; $display("FAIL rand_b_%0d got=%b exp=%b", k, ctl_b, exp_ctl(rem_b));
         end
         tick();
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_load_use();
      test_mem_wait();
      test_branch_vs_lu();
      test_reset_mid_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation hazard/forwarding controller for the pipelined RV32I core.
- Generalises EX-stage operand forwarding to NSTG downstream result stages with a priority encoder. Nearest stage wins.
- Adds sequential hazard control:
  - multi-bubble load-use stall FSM;
  - data-memory wait stall;
  - branch-taken flush.
- Sits beside the datapath and drives stall/flush enables of the F/D/E/M/W pipeline registers and the EX operand muxes.

Parameters:
- NSTG, 2: number of forwarding source stages after EX. Index 0 is nearest (M), index NSTG-1 is farthest (W). Legal range 1..6.
- LU_BUBBLES, 1: bubbles inserted per load-use hazard. Legal range 1..7.
- FW, $clog2(NSTG+1): width of the forward-select codes (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5 each  source/destination registers in Execute.
- RegWriteE  in  1  Execute instruction writes rd.
- ResultSrcE0  in  1  Execute instruction is a load.
- PCSrcE  in  1  branch/jump taken, resolved in Execute.
- RdS  in  5*NSTG  destination regs of stages 0..NSTG-1. Stage i occupies bits [5i+4:5i].
- RegWriteS  in  NSTG  per-stage write enables.
- MemReqM  in  1  data memory access active in M.
- MemReadyM  in  1  data memory completes this cycle.
- ForwardA, ForwardB  out  FW each  operand select codes.
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline registers.
- FlushD, FlushE, FlushW  out  1 each  insert bubbles.

Behaviour:
- Forwarding (combinational):
  - Stage i matches Rs1E when RegWriteS[i], RdS[i] != 0 and RdS[i] == Rs1E.
  - ForwardA = NSTG - i for the lowest matching i; 0 (register file) if no stage matches.
  - ForwardB is the same computation using Rs2E.
  - With NSTG=2 the codes are 2'b10 (M), 2'b01 (W) and 2'b00 (register file).
- Hazard terms:
  - lu_hz = ResultSrcE0 & RegWriteE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - mw = MemReqM & ~MemReadyM.
- Priority, highest first: mw > PCSrcE > load-use.
- State machine: states RUN and LU_STALL. Down-counter cnt is $clog2(LU_BUBBLES+1) bits wide. Reset gives state=RUN, cnt=0.
- mw asserted, in any state:
  - StallF, StallD, StallE and StallM = 1, FlushW = 1.
  - FlushD and FlushE = 0.
  - State and cnt hold.
  - A taken branch is deferred: E is held, so PCSrcE re-presents when mw drops.
- RUN, no mw, PCSrcE=1:
  - FlushD = FlushE = 1.
  - Any lu_hz is ignored; state stays RUN.
- RUN, no mw, no PCSrcE, lu_hz=1:
  - StallF = StallD = FlushE = 1 this cycle.
  - If LU_BUBBLES > 1: next state LU_STALL, cnt = LU_BUBBLES-1.
- LU_STALL, no mw:
  - StallF = StallD = FlushE = 1.
  - cnt decrements each cycle.
  - When cnt == 1 the next state is RUN.
- All stall/flush outputs not listed for a case are 0.
- While rst is high, all stall/flush outputs are forced to 0. Forward outputs stay combinational.
- Reset mid-stall returns to RUN immediately, and the bubble sequence is abandoned.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, two outputs are added:
  - lu_stall_cnt: 32-bit count of cycles with lu-driven StallD and no mw.
  - mem_stall_cnt: 32-bit count of cycles with mw.
- Both counters are saturating, reset to 0, and update on clk.
- When undefined, neither the ports nor the counter logic exist.

Test Plan:
- Forwarding priority: NSTG=2, RdS={5'd3,5'd3}, RegWriteS=2'b11, Rs1E=3 -> ForwardA=2'b10. Repeat with RegWriteS=2'b10 (W only) -> 2'b01. Repeat with RdS[0]=0 and Rs2E=0 -> ForwardB=0.
- NSTG=4: x5 matches stages 2 and 3 only -> ForwardA=3'd2.
- Load-use, LU_BUBBLES=1: load RdE=7, Rs2D=7 -> StallF, StallD and FlushE high for exactly 1 cycle. Next cycle (load in M) all clear.
- Multi-bubble, LU_BUBBLES=3: same hazard -> StallF, StallD and FlushE high for 3 consecutive cycles, then state returns to RUN.
- Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles, injected during the 2nd LU_STALL cycle:
  - StallF/D/E/M and FlushW are high for 4 cycles, FlushE=0, and cnt is frozen.
  - After MemReadyM=1 the remaining 2 bubbles complete.
- Branch vs load-use, and reset: PCSrcE=1 with lu_hz=1 -> FlushD=FlushE=1, StallF=0, and no LU_STALL entry. Asserting rst in LU_STALL -> outputs drop to 0 asynchronously and the state is RUN after release.
